// File: rtl/wave_pwm_dac_pkg.sv
// wave_pwm_dac_pkg: shared waveform select encoding and default sample width
package wave_pwm_dac_pkg;
  localparam int WIDTH_DEF = 8;
  localparam logic [2:0] SEL_SQUARE     = 3'd0;
  localparam logic [2:0] SEL_TRIANGLE   = 3'd1;
  localparam logic [2:0] SEL_SINE       = 3'd2;
  localparam logic [2:0] SEL_FULL_RECT  = 3'd3;
  localparam logic [2:0] SEL_HALF_RECT  = 3'd4;
  localparam logic [2:0] SEL_RECIPROCAL = 3'd5;
endpackage

// File: rtl/wave_pwm_dac_pwm_core.sv
// pwm_core: free-running counter, period-boundary duty latch, registered compare and tick
module pwm_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] scaled,
  output logic             pwm_out,
  output logic             sample_tick,
  output logic [WIDTH-1:0] cur_sample
);
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty;
  logic             last;
  assign last       = &cnt;
  assign cur_sample = duty;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      duty        <= '0;
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      pwm_out     <= cnt < duty;
      sample_tick <= last;
      duty        <= last ? scaled : duty;
    end
  end
endmodule

// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac: selects and attenuates a generator waveform and emits it as glitch-free PWM
module wave_pwm_dac
  import wave_pwm_dac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMP_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       slc,
  input  logic [AMP_W-1:0] amp,
  input  logic [WIDTH-1:0] square,
  input  logic [WIDTH-1:0] triangle,
  input  logic [WIDTH-1:0] full_wave_rectified,
  input  logic [WIDTH-1:0] half_wave_rectified,
  input  logic [WIDTH-1:0] reciprocal,
  input  logic [WIDTH-1:0] sine,
  output logic             pwm_out,
  output logic             sample_tick,
  output logic [WIDTH-1:0] cur_sample
);
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] scaled;
  always_comb begin
    sel    = slc == SEL_SQUARE     ? square :
             slc == SEL_TRIANGLE   ? triangle :
             slc == SEL_SINE       ? sine :
             slc == SEL_FULL_RECT  ? full_wave_rectified :
             slc == SEL_HALF_RECT  ? half_wave_rectified :
             slc == SEL_RECIPROCAL ? reciprocal : '0;
    scaled = sel >> amp;
  end
  pwm_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .scaled      (scaled),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .cur_sample  (cur_sample)
  );
endmodule
